calculator_alu: RTL and testbench
=================================

# calculator_alu

Arithmetic responder for the calculator core's ALU request/result interface. It accepts one operand pair and opcode per valid/ready handshake and computes ADD, SUB, MUL or DIV, signed or unsigned. It returns one result word with an error flag over a second valid/ready handshake. ADD and SUB complete in one cycle; MUL and DIV are iterative, one bit per cycle.

## Interface
- DATA_WIDTH, 16, operand/result width; must be ≥ 4.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_input_a  input  DATA_WIDTH  operand A (dividend / minuend).
- i_input_b  input  DATA_WIDTH  operand B (divisor / subtrahend).
- i_input_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- i_input_signed  input  1  1: two's complement operands; 0: unsigned.
- i_input_valid  input  1  request valid.
- o_input_ready  output  1  high only in IDLE.
- o_result  output  DATA_WIDTH  result word; 0 whenever o_error=1.
- o_error  output  1  overflow or divide-by-zero.
- o_result_valid  output  1  result valid; high only in DONE.
- i_result_ready  input  1  consumer accepts result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: when i_input_valid && o_input_ready, latch the operands, op and signed flag.
  - ADD/SUB: compute and check overflow at accept; go to DONE.
  - MUL: go to MUL.
  - DIV with B==0: set error and go to DONE.
  - Other DIV: go to DIV.
- Signed MUL/DIV: on accept, store the operand magnitudes and result sign = sign(A) XOR sign(B). Negate the final magnitude when the sign bit is set.
- MUL: shift-add over a 2·DATA_WIDTH accumulator, DATA_WIDTH iterations, iteration counter 0..DATA_WIDTH-1. Then go to DONE.
- DIV: restoring division, DATA_WIDTH iterations. The quotient truncates toward zero; the remainder is discarded. Then go to DONE.
- DONE: hold o_result and o_error stable. On i_result_ready, return to IDLE.
- Error conditions, checked on the exact result:
  - Unsigned ADD: carry out.
  - Unsigned SUB: A<B.
  - Signed ADD/SUB: sign overflow.
  - MUL: the full product does not fit in DATA_WIDTH bits. Unsigned: high half nonzero. Signed: outside [-2^(W-1), 2^(W-1)-1].
  - DIV: B==0, or signed A==-2^(W-1) with B==-1.
- i_input_* are ignored while o_input_ready=0. They need not be held after acceptance.

## Timing
- Reset: state IDLE, o_input_ready=1, o_result_valid=0, o_result=0, o_error=0, counter=0. This applies on any cycle, including mid-MUL/DIV and in DONE; any in-flight or unread result is dropped.
- Count latency from the accept edge to the first cycle o_result_valid=1:
  - ADD/SUB and divide-by-zero: 1 cycle.
  - MUL and DIV: DATA_WIDTH+1 cycles.
- Result handshake at edge k: o_result_valid falls and o_input_ready rises after edge k. The next request is accepted no earlier than edge k+1, so there is one bubble per operation.
- Backpressure is unlimited: DONE holds indefinitely with outputs unchanged.
- o_input_ready and o_result_valid are never high together.

## Configuration
- CALC_ALU_FAST_MUL_EN defined: MUL uses a single-cycle combinational DATA_WIDTH×DATA_WIDTH signed/unsigned multiply at accept and goes straight to DONE, so MUL latency is 1. The MUL state is unreachable.
- Undefined: the iterative MUL described above, with latency DATA_WIDTH+1.
- DIV, error rules and result values are identical in both builds.

## Structure
- calculator_pkg holds:
  - alu_op_t enum: ALU_ADD=2'b00, ALU_SUB, ALU_MUL, ALU_DIV.
  - alu_state_t enum: IDLE, MUL, DIV, DONE.
  - The error-code localparams.
- The calculator core imports the same package for its opcode encoding.
- One sub-module, calculator_alu_divider, implements the iterative unsigned restoring divider. Its interface is start, dividend, divisor, busy, done and quotient. The top module handles the sign pre- and post-processing.

## Test plan
- Unsigned ADD 100+23: result 123, error 0, valid 1 cycle after accept. Unsigned 0xFFFF+1: result 0, error 1.
- Unsigned SUB 3−5: error 1, result 0. Signed SUB 3−5: result 0xFFFE, error 0. Signed 0x7FFF+1: error 1.
- Signed MUL −7×6: result 0xFFD6, valid after 17 cycles, or 1 with CALC_ALU_FAST_MUL_EN. Unsigned 300×300: error 1. Signed 0x8000×1: 0x8000, error 0.
- Signed DIV −100÷7: result 0xFFF2 after 17 cycles. DIV by 0: error 1 after 1 cycle. Signed 0x8000÷0xFFFF: error 1. Unsigned 0xFFFF÷0x0010: result 0x0FFF.
- Backpressure: hold i_result_ready low 5 cycles after valid. o_result and o_error are stable and o_input_ready stays 0. On release, ready rises the next cycle and a back-to-back request is accepted with one bubble.
- Assert rst during MUL iteration 8 and during DONE: next cycle is IDLE, o_result_valid 0, o_result 0, no stale result appears, and a fresh request completes correctly.

Source files
------------

// File: rtl/calculator_pkg.sv
// calculator_pkg: opcode, FSM state and error-cause encodings shared by the calculator core and its ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calculator_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_DIV = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      DONE = 2'b11
   } alu_state_t;

   // Error causes held internally; the port only exposes "any error".
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_DIV_ZERO = 2'd2;

endpackage

// File: rtl/calculator_alu_divider.sv
// calculator_alu_divider: iterative unsigned restoring divider, one quotient bit per cycle, remainder dropped.
// Latency: first step on the start edge, done pulses for one cycle after DATA_WIDTH steps; quotient then stable.
// Backpressure: none; start is only issued when idle, quotient holds until the next start.
// Ports: clk, rst (sync, active-high); start/dividend/divisor in; busy, done, quotient out.
module calculator_alu_divider #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   logic [W-1:0]  rem_q, quo_q, dsr_q;
   logic [CW-1:0] cnt;
   logic [W-1:0]  rem_in, quo_in, dsr_in, rem_step, quo_step;
   logic [W:0]    rem_sh, diff;

   // The first step runs straight off the fresh operands on the start edge, so the
   // divider finishes one cycle earlier than a load-then-iterate scheme.
   always_comb begin
      rem_in = start ? {W{1'b0}} : rem_q;
      quo_in = start ? dividend  : quo_q;
      dsr_in = start ? divisor   : dsr_q;
      rem_sh = {rem_in, quo_in[W-1]};
      diff   = rem_sh - {1'b0, dsr_in};
      // Borrow out of the W+1-bit subtraction means the trial remainder went negative: restore.
      if (diff[W]) begin
         rem_step = rem_sh[W-1:0];
         quo_step = {quo_in[W-2:0], 1'b0};
      end else begin
         rem_step = diff[W-1:0];
         quo_step = {quo_in[W-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            dsr_q <= divisor;
            cnt   <= CW'(1);
            busy  <= 1'b1;
         end else if (busy) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (cnt == CW'(W-1)) begin
               busy <= 1'b0;
               done <= 1'b1;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign quotient = quo_q;

endmodule

// File: rtl/calculator_alu.sv
// calculator_alu: valid/ready ALU responder, ADD/SUB/MUL/DIV signed or unsigned, result word plus error flag.
// Latency: ADD/SUB and divide-by-zero 1 cycle; MUL and DIV DATA_WIDTH+1 (MUL 1 with CALC_ALU_FAST_MUL_EN).
// Backpressure: DONE holds result/error unchanged until i_result_ready; one bubble per operation.
// Ports: clk, rst (sync, active-high); i_input_a/b/op/signed/valid + o_input_ready request side;
//        o_result, o_error, o_result_valid + i_result_ready response side.
// Build option: CALC_ALU_FAST_MUL_EN selects a single-cycle combinational multiply (MUL state unused).
module calculator_alu
   import calculator_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_input_a,
   input  logic [DATA_WIDTH-1:0] i_input_b,
   input  logic [1:0]            i_input_op,
   input  logic                  i_input_signed,
   input  logic                  i_input_valid,
   output logic                  o_input_ready,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_error,
   output logic                  o_result_valid,
   input  logic                  i_result_ready
);
   localparam int W = DATA_WIDTH;
   localparam logic [2*W-1:0] MAG_LIM = (2*W)'(1) << (W-1);

   // Magnitude product -> {error, result}; a negative result may reach 2^(W-1), a positive one may not.
   function automatic logic [W:0] mul_final(input logic [2*W-1:0] p, input logic neg, input logic sgn);
      logic err;
      if (sgn) err = neg ? (p > MAG_LIM) : (p >= MAG_LIM);
      else     err = |p[2*W-1:W];
      return {err, err ? {W{1'b0}} : (neg ? (W'(0) - p[W-1:0]) : p[W-1:0])};
   endfunction

   // Quotient magnitude -> {error, result}; only -2^(W-1) / -1 yields a positive 2^(W-1).
   function automatic logic [W:0] div_final(input logic [W-1:0] q, input logic neg, input logic sgn);
      logic err;
      err = sgn & ~neg & q[W-1];
      return {err, err ? {W{1'b0}} : (neg ? (W'(0) - q) : q)};
   endfunction

   alu_state_t   state, state_nxt;
   alu_op_t      op_in;
   logic         accept, a_neg, b_neg, b_zero;
   logic [W-1:0] mag_a, mag_b;
   logic [W-1:0] result_q;
   logic [1:0]   err_q;
   logic         sgn_q, neg_q;

   assign op_in  = alu_op_t'(i_input_op);
   assign accept = i_input_valid && (state == IDLE);
   assign a_neg  = i_input_signed & i_input_a[W-1];
   assign b_neg  = i_input_signed & i_input_b[W-1];
   assign mag_a  = a_neg ? (W'(0) - i_input_a) : i_input_a;
   assign mag_b  = b_neg ? (W'(0) - i_input_b) : i_input_b;
   assign b_zero = (i_input_b == '0);

   // ADD/SUB resolve entirely at accept.
   logic [W:0]   add_full;
   logic [W-1:0] sub_diff, addsub_res;
   logic         addsub_err;
   assign add_full = {1'b0, i_input_a} + {1'b0, i_input_b};
   assign sub_diff = i_input_a - i_input_b;

   always_comb begin
      addsub_res = add_full[W-1:0];
      addsub_err = 1'b0;
      if (op_in == ALU_ADD) begin
         if (i_input_signed) addsub_err = (i_input_a[W-1] == i_input_b[W-1]) && (add_full[W-1] != i_input_a[W-1]);
         else                addsub_err = add_full[W];
      end else begin
         addsub_res = sub_diff;
         if (i_input_signed) addsub_err = (i_input_a[W-1] != i_input_b[W-1]) && (sub_diff[W-1] != i_input_a[W-1]);
         else                addsub_err = (i_input_a < i_input_b);
      end
      if (addsub_err) addsub_res = '0;
   end

   logic [W:0] mul_out;
   logic       mul_last;

`ifndef CALC_ALU_FAST_MUL_EN
   localparam int CW = $clog2(W);
   // Shift-add: low half starts as the multiplier and drains out LSB-first as the product fills in.
   logic [2*W-1:0] acc, acc_nxt;
   logic [W-1:0]   mcand;
   logic [CW-1:0]  cnt;
   logic [W:0]     mul_sum;

   assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
   assign acc_nxt  = {mul_sum, acc[W-1:1]};
   assign mul_last = (state == MUL) && (cnt == CW'(W-1));
   assign mul_out  = mul_final(acc_nxt, neg_q, sgn_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (accept && (op_in == ALU_MUL)) begin
         acc   <= {{W{1'b0}}, mag_b};
         mcand <= mag_a;
         cnt   <= '0;
      end else if (state == MUL) begin
         acc <= acc_nxt;
         cnt <= mul_last ? '0 : cnt + 1'b1;
      end
   end
`else
   assign mul_out  = mul_final({{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b}, a_neg ^ b_neg, i_input_signed);
   assign mul_last = 1'b0;
`endif

   logic         div_start, div_busy, div_done, div_fin;
   logic [W-1:0] div_quot;
   logic [W:0]   div_out;

   assign div_start = accept && (op_in == ALU_DIV) && !b_zero;
   assign div_fin   = div_done && !div_busy;
   assign div_out   = div_final(div_quot, neg_q, sgn_q);

   calculator_alu_divider #(.DATA_WIDTH(W)) u_divider (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (mag_a),
      .divisor  (mag_b),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            case (op_in)
`ifdef CALC_ALU_FAST_MUL_EN
               ALU_MUL: state_nxt = DONE;
`else
               ALU_MUL: state_nxt = MUL;
`endif
               ALU_DIV: state_nxt = b_zero ? DONE : DIV;
               default: state_nxt = DONE;
            endcase
         end
         MUL:  if (mul_last) state_nxt = DONE;
         DIV:  if (div_fin) state_nxt = DONE;
         DONE: if (i_result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         err_q    <= ERR_NONE;
         sgn_q    <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sgn_q    <= i_input_signed;
               neg_q    <= a_neg ^ b_neg;
               result_q <= '0;
               err_q    <= ERR_NONE;
               case (op_in)
                  ALU_ADD, ALU_SUB: begin
                     result_q <= addsub_res;
                     err_q    <= addsub_err ? ERR_OVERFLOW : ERR_NONE;
                  end
`ifdef CALC_ALU_FAST_MUL_EN
                  ALU_MUL: begin
                     result_q <= mul_out[W-1:0];
                     err_q    <= mul_out[W] ? ERR_OVERFLOW : ERR_NONE;
                  end
`endif
                  ALU_DIV: if (b_zero) err_q <= ERR_DIV_ZERO;
                  default: ;
               endcase
            end
            MUL: if (mul_last) begin
               result_q <= mul_out[W-1:0];
               err_q    <= mul_out[W] ? ERR_OVERFLOW : ERR_NONE;
            end
            DIV: if (div_fin) begin
               result_q <= div_out[W-1:0];
               err_q    <= div_out[W] ? ERR_OVERFLOW : ERR_NONE;
            end
            DONE: if (i_result_ready) begin
               result_q <= '0;
               err_q    <= ERR_NONE;
            end
            default: ;
         endcase
      end
   end

   assign o_input_ready  = (state == IDLE);
   assign o_result_valid = (state == DONE);
   assign o_result       = result_q;
   assign o_error        = (err_q != ERR_NONE);

endmodule

// File: tb/tb_calculator_alu.sv
// tb_calculator_alu: directed vectors with a queue-based scoreboard checking value, error and latency.
// Latency: expectations use 1 cycle for ADD/SUB/div-by-zero, DATA_WIDTH+1 for DIV and iterative MUL.
// Backpressure: exercises a 5-cycle result stall, back-to-back issue, and reset mid-MUL and in DONE.
`timescale 1ns/1ps
module tb_calculator_alu;
   localparam int W = 16;
`ifdef CALC_ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] i_input_a = '0, i_input_b = '0;
   logic [1:0]   i_input_op = '0;
   logic         i_input_signed = 1'b0, i_input_valid = 1'b0, i_result_ready = 1'b1;
   logic         o_input_ready, o_error, o_result_valid;
   logic [W-1:0] o_result;

   calculator_alu #(.DATA_WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_input_a      (i_input_a),
      .i_input_b      (i_input_b),
      .i_input_op     (i_input_op),
      .i_input_signed (i_input_signed),
      .i_input_valid  (i_input_valid),
      .o_input_ready  (o_input_ready),
      .o_result       (o_result),
      .o_error        (o_error),
      .o_result_valid (o_result_valid),
      .i_result_ready (i_result_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] exp_res_q[$];
   logic         exp_err_q[$];
   int           exp_lat_q[$];
   string        exp_name_q[$];
   int           acc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: records accept edges and scores each new result against the head of the queue.
   logic         prev_valid = 1'b0;
   string        mon_name;
   int           mon_acc;
   always @(negedge clk) begin
      if (!rst && i_input_valid && o_input_ready) acc_q.push_back(cyc + 1);
      if (cyc > 0) check("ready_valid_exclusive", 32'(o_input_ready && o_result_valid), 32'd0);
      if (o_result_valid && !prev_valid) begin
         if (exp_res_q.size() == 0 || acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_result: actual result 0x%0h with nothing outstanding, required no result", o_result);
         end else begin
            mon_name = exp_name_q.pop_front();
            mon_acc  = acc_q.pop_front();
            check({mon_name, "_result"},  32'(o_result), 32'(exp_res_q.pop_front()));
            check({mon_name, "_error"},   32'(o_error),  32'(exp_err_q.pop_front()));
            check({mon_name, "_latency"}, 32'(cyc - mon_acc + 1), 32'(exp_lat_q.pop_front()));
         end
      end
      prev_valid = o_result_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string nm, input logic [W-1:0] r, input logic e, input int l);
      exp_name_q.push_back(nm);
      exp_res_q.push_back(r);
      exp_err_q.push_back(e);
      exp_lat_q.push_back(l);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input logic sg);
      i_input_a      = a;
      i_input_b      = b;
      i_input_op     = op;
      i_input_signed = sg;
      i_input_valid  = 1'b1;
   endtask

   // Inputs are scrambled right after acceptance: the DUT must not depend on them being held.
   task automatic scramble();
      i_input_valid  = 1'b0;
      i_input_a      = W'($urandom);
      i_input_b      = W'($urandom);
      i_input_op     = 2'($urandom);
      i_input_signed = 1'($urandom);
   endtask

   task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic sg, input logic [W-1:0] er, input logic ee, input int el);
      int t = 0;
      while (!o_input_ready && t < 100) begin tick(); t++; end
      check({nm, "_ready_at_issue"}, 32'(o_input_ready), 32'd1);
      push_exp(nm, er, ee, el);
      drive(a, b, op, sg);
      tick();
      scramble();
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while (!(o_input_ready && exp_res_q.size() == 0) && t < 100) begin tick(); t++; end
      check({nm, "_completed_in_budget"}, 32'(t < 100), 32'd1);
   endtask

   task automatic do_reset();
      exp_name_q.delete();
      exp_res_q.delete();
      exp_err_q.delete();
      exp_lat_q.delete();
      acc_q.delete();
      i_input_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_idle_state(input string nm);
      check({nm, "_input_ready"},  32'(o_input_ready),  32'd1);
      check({nm, "_result_valid"}, 32'(o_result_valid), 32'd0);
      check({nm, "_result"},       32'(o_result),       32'd0);
      check({nm, "_error"},        32'(o_error),        32'd0);
   endtask

   task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic sg, input logic [W-1:0] er, input logic ee, input int el);
      issue(nm, a, b, op, sg, er, ee, el);
      wait_idle(nm);
   endtask

   task automatic expect_quiet(input string nm, input int cycles);
      logic seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (o_result_valid) seen = 1'b1;
         tick();
      end
      check({nm, "_no_result"}, 32'(seen), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      check_idle_state("reset_held");
      rst = 1'b0;
      tick();
      check_idle_state("reset_released");

      // name                a        b        op      sg    result   err   latency
      run("uadd_100_23",   16'd100, 16'd23,  OP_ADD, 1'b0, 16'd123,  1'b0, 1);
      run("uadd_carry",    16'hFFFF,16'h0001,OP_ADD, 1'b0, 16'h0000, 1'b1, 1);
      run("usub_3_5",      16'd3,   16'd5,   OP_SUB, 1'b0, 16'h0000, 1'b1, 1);
      run("usub_5_3",      16'd5,   16'd3,   OP_SUB, 1'b0, 16'h0002, 1'b0, 1);
      run("ssub_3_5",      16'd3,   16'd5,   OP_SUB, 1'b1, 16'hFFFE, 1'b0, 1);
      run("sadd_max_1",    16'h7FFF,16'h0001,OP_ADD, 1'b1, 16'h0000, 1'b1, 1);
      run("sadd_min_m1",   16'h8000,16'hFFFF,OP_ADD, 1'b1, 16'h0000, 1'b1, 1);
      run("smul_m7_6",     16'hFFF9,16'd6,   OP_MUL, 1'b1, 16'hFFD6, 1'b0, MUL_LAT);
      run("umul_300_300",  16'd300, 16'd300, OP_MUL, 1'b0, 16'h0000, 1'b1, MUL_LAT);
      run("umul_255_255",  16'd255, 16'd255, OP_MUL, 1'b0, 16'hFE01, 1'b0, MUL_LAT);
      run("smul_min_1",    16'h8000,16'h0001,OP_MUL, 1'b1, 16'h8000, 1'b0, MUL_LAT);
      run("smul_m1_m1",    16'hFFFF,16'hFFFF,OP_MUL, 1'b1, 16'h0001, 1'b0, MUL_LAT);
      run("smul_pos_2p15", 16'h0100,16'h0080,OP_MUL, 1'b1, 16'h0000, 1'b1, MUL_LAT);
      run("smul_neg_2p15", 16'hFF00,16'h0080,OP_MUL, 1'b1, 16'h8000, 1'b0, MUL_LAT);
      run("sdiv_m100_7",   16'hFF9C,16'd7,   OP_DIV, 1'b1, 16'hFFF2, 1'b0, DIV_LAT);
      run("sdiv_100_m7",   16'd100, 16'hFFF9,OP_DIV, 1'b1, 16'hFFF2, 1'b0, DIV_LAT);
      run("udiv_by_zero",  16'd1234,16'd0,   OP_DIV, 1'b0, 16'h0000, 1'b1, 1);
      run("sdiv_min_m1",   16'h8000,16'hFFFF,OP_DIV, 1'b1, 16'h0000, 1'b1, DIV_LAT);
      run("udiv_ffff_10",  16'hFFFF,16'h0010,OP_DIV, 1'b0, 16'h0FFF, 1'b0, DIV_LAT);

      // Backpressure: result held 5 cycles while the next request waits on the input side.
      i_result_ready = 1'b0;
      issue("bp_add", 16'h1111, 16'h2222, OP_ADD, 1'b0, 16'h3333, 1'b0, 1);
      drive(16'h0010, 16'h0020, OP_SUB, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_result", 32'(o_result),       32'h3333);
         check("bp_hold_error",  32'(o_error),        32'd0);
         check("bp_hold_valid",  32'(o_result_valid), 32'd1);
         check("bp_hold_ready",  32'(o_input_ready),  32'd0);
         tick();
      end
      push_exp("bp_next_sub", 16'hFFF0, 1'b0, 1);
      i_result_ready = 1'b1;
      tick();
      check("bp_bubble_ready", 32'(o_input_ready),  32'd1);
      check("bp_bubble_valid", 32'(o_result_valid), 32'd0);
      tick();
      scramble();
      check("bp_next_accepted", 32'(o_input_ready), 32'd0);
      wait_idle("bp_next_sub");

      // Reset while the multiplier is on iteration 8.
      issue("rst_mul_dropped", 16'd3, 16'd4, OP_MUL, 1'b1, 16'd12, 1'b0, MUL_LAT);
      for (int i = 0; i < 8; i++) tick();
      do_reset();
      check_idle_state("rst_mid_mul");
      expect_quiet("rst_mid_mul", 25);
      run("rst_mul_fresh", 16'd12, 16'd13, OP_MUL, 1'b0, 16'h009C, 1'b0, MUL_LAT);

      // Reset while a result sits unread in DONE.
      i_result_ready = 1'b0;
      issue("rst_done_add", 16'd5, 16'd6, OP_ADD, 1'b0, 16'd11, 1'b0, 1);
      tick();
      tick();
      do_reset();
      check_idle_state("rst_in_done");
      i_result_ready = 1'b1;
      expect_quiet("rst_in_done", 5);
      run("rst_done_fresh", 16'd1000, 16'd3, OP_DIV, 1'b0, 16'h014D, 1'b0, DIV_LAT);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500us, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
